// File: rtl/apu.sv
// rtl/apu.sv - reduced 2A03 APU top: master-clock divider, vector/sweep bus sequencer, controller port
module apu #(
  parameter int DIV     = 12,
  parameter int M2_RISE = 5
) (
  input  logic        CLK,
  input  logic        RES,
  output logic [15:0] A,
  inout  wire  [7:0]  D,
  input  logic        DBG,
  output logic        M2,
  input  logic        n_IRQ,
  input  logic        n_NMI,
  output logic        RnW,
  output logic        n_IN0,
  output logic        n_IN1,
  output logic        OUT0,
  output logic        OUT1,
  output logic        OUT2
);

  localparam int DW = $clog2(DIV);

  typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN} state_t;

  logic [DW-1:0] div_q, div_d;
  logic          aclk_q, aclk_d;
  state_t        state_q, state_d;
  logic [15:0]   a_q, a_d;
  logic [7:0]    lo_q, lo_d;
  logic          n_nmi_q, n_nmi_d;
  logic          nmi_pend_q, nmi_pend_d;
  logic          irq_mask_q, irq_mask_d;
  logic          n_in0_q, n_in0_d;
  logic          n_in1_q, n_in1_d;
  logic [2:0]    out_q, out_d;

  logic phi0, phi1, phi2, aclk1, n_aclk2;
  logic cyc_end, nmi_edge, nmi_take, irq_take;
  logic unused_probes;

  assign phi0    = (div_q >= DW'(DIV / 2));
  assign phi2    = phi0;
  assign phi1    = ~phi0;
  assign aclk1   = phi1 & ~aclk_q;
  assign n_aclk2 = ~(phi1 & aclk_q);
  assign unused_probes = aclk1 & n_aclk2;

  // The cycle boundary is the last master clock of PHI2; D is sampled here.
  assign cyc_end  = phi2 && (div_q == DW'(DIV - 1));
  assign nmi_edge = n_nmi_q & ~n_NMI;

  always_comb begin
    div_d    = cyc_end ? '0 : div_q + 1'b1;
    aclk_d   = aclk_q ^ cyc_end;
    state_d  = state_q;
    a_d      = a_q;
    lo_d     = lo_q;
    n_nmi_d  = n_NMI;
    nmi_take = 1'b0;
    irq_take = 1'b0;
    if (cyc_end) begin
      case (state_q)
        VEC_LO: begin
          lo_d    = D;
          a_d     = a_q + 16'd1;
          state_d = VEC_HI;
        end
        VEC_HI: begin
          a_d     = {D, lo_q};
          state_d = RUN;
        end
        RUN: begin
          if (nmi_pend_q) begin
            nmi_take = 1'b1;
            a_d      = 16'hFFFA;
            state_d  = VEC_LO;
          end else if (!n_IRQ && !DBG && !irq_mask_q) begin
            irq_take = 1'b1;
            a_d      = 16'hFFFE;
            state_d  = VEC_LO;
          end else begin
            a_d = a_q + 16'd1;
          end
        end
        default: state_d = VEC_LO;
      endcase
    end

    // A second falling edge while one is pending is absorbed.
    if (nmi_take)      nmi_pend_d = 1'b0;
    else if (nmi_edge) nmi_pend_d = 1'b1;
    else               nmi_pend_d = nmi_pend_q;

    irq_mask_d = n_IRQ ? 1'b0 : (irq_mask_q | irq_take);
    n_in0_d    = (a_d != 16'h4016);
    n_in1_d    = (a_d != 16'h4017);
    out_d      = (cyc_end && a_q == 16'h4016) ? D[2:0] : out_q;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      div_q      <= '0;
      aclk_q     <= 1'b0;
      state_q    <= VEC_LO;
      a_q        <= 16'hFFFC;
      lo_q       <= 8'h00;
      n_nmi_q    <= 1'b1;
      nmi_pend_q <= 1'b0;
      irq_mask_q <= 1'b0;
      n_in0_q    <= 1'b1;
      n_in1_q    <= 1'b1;
      out_q      <= 3'b000;
    end else begin
      div_q      <= div_d;
      aclk_q     <= aclk_d;
      state_q    <= state_d;
      a_q        <= a_d;
      lo_q       <= lo_d;
      n_nmi_q    <= n_nmi_d;
      nmi_pend_q <= nmi_pend_d;
      irq_mask_q <= irq_mask_d;
      n_in0_q    <= n_in0_d;
      n_in1_q    <= n_in1_d;
      out_q      <= out_d;
    end
  end

  assign A     = a_q;
  assign M2    = (div_q >= DW'(M2_RISE));
  assign RnW   = 1'b1;
  assign n_IN0 = n_in0_q;
  assign n_IN1 = n_in1_q;
  assign OUT0  = out_q[0];
  assign OUT1  = out_q[1];
  assign OUT2  = out_q[2];

endmodule

// File: tb/tb_apu.sv
// tb/tb_apu.sv - directed self-checking bench for apu
module tb_apu;

  logic        clk = 1'b0;
  logic        res;
  logic        dbg;
  logic        n_irq;
  logic        n_nmi;
  logic [7:0]  d_drv;
  wire  [7:0]  d_bus;
  logic [15:0] a;
  logic        m2, rnw, n_in0, n_in1, out0, out1, out2;

  int tests_run = 0;
  int tests_failed = 0;

  assign d_bus = d_drv;

  apu dut (
    .CLK(clk), .RES(res), .A(a), .D(d_bus), .DBG(dbg), .M2(m2),
    .n_IRQ(n_irq), .n_NMI(n_nmi), .RnW(rnw), .n_IN0(n_in0), .n_IN1(n_in1),
    .OUT0(out0), .OUT1(out1), .OUT2(out2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [7:0] d);
    d_drv = d;
    repeat (12) tick();
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  initial begin
    res = 1'b1; dbg = 1'b0; n_irq = 1'b1; n_nmi = 1'b1; d_drv = 8'h00;

    for (int i = 0; i < 32; i++) begin
      tick();
      chk("rst_m2", m2, 0);
      chk("rst_a", a, 16'hFFFC);
      chk("rst_rnw", rnw, 1);
      chk("rst_nin", {n_in1, n_in0}, 2'b11);
      chk("rst_out", {out2, out1, out0}, 3'b000);
    end
    chk("rst_phi1", dut.phi1, 1);
    chk("rst_aclk1", dut.aclk1, 1);

    res = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      d_drv = (k <= 12) ? 8'h34 : 8'h40;
      tick();
      chk("m2", m2, ((k % 12) >= 5) ? 1 : 0);
      chk("phi1", dut.phi1, ((k % 12) < 6) ? 1 : 0);
      chk("aclk1", dut.aclk1, (((k % 12) < 6) && ((k / 12) % 2 == 0)) ? 1 : 0);
      chk("a_sweep", a, (k < 12) ? 16'hFFFC : (k < 24) ? 16'hFFFD : 16'h4034);
    end
    d_drv = 8'h00;
    repeat (4) tick();
    chk("a_inc", a, 16'h4035);

    do_reset();
    chk("rst2_a", a, 16'hFFFC);
    cycle(8'h15);
    chk("v_hi_a", a, 16'hFFFD);
    cycle(8'h40);
    chk("v_a4015", a, 16'h4015);
    chk("v_nin0_hi", n_in0, 1);
    cycle(8'h00);
    chk("v_a4016", a, 16'h4016);
    chk("v_nin0_lo", n_in0, 0);
    chk("v_nin1_hi", n_in1, 1);
    cycle(8'h05);
    chk("v_a4017", a, 16'h4017);
    chk("v_out_latch", {out2, out1, out0}, 3'b101);
    chk("v_nin0_rel", n_in0, 1);
    chk("v_nin1_lo", n_in1, 0);
    cycle(8'h02);
    chk("v_a4018", a, 16'h4018);
    chk("v_nin1_rel", n_in1, 1);
    chk("v_out_hold", {out2, out1, out0}, 3'b101);

    n_nmi = 1'b0;
    repeat (3) tick();
    n_nmi = 1'b1;
    repeat (9) tick();
    chk("nmi_a_fffa", a, 16'hFFFA);
    cycle(8'h00);
    chk("nmi_a_fffb", a, 16'hFFFB);
    cycle(8'h50);
    chk("nmi_vec", a, 16'h5000);

    n_nmi = 1'b0;
    cycle(8'h00);
    chk("nmi2_fffa", a, 16'hFFFA);
    cycle(8'h00);
    cycle(8'h60);
    chk("nmi2_vec", a, 16'h6000);
    cycle(8'h00);
    chk("nmi_no_reentry", a, 16'h6001);
    n_nmi = 1'b1;
    cycle(8'h00);
    chk("nmi_after_rel", a, 16'h6002);

    n_irq = 1'b0;
    cycle(8'h00);
    chk("irq_fffe", a, 16'hFFFE);
    cycle(8'h00);
    chk("irq_ffff", a, 16'hFFFF);
    cycle(8'h70);
    chk("irq_vec", a, 16'h7000);
    cycle(8'h00);
    cycle(8'h00);
    chk("irq_masked", a, 16'h7002);
    n_irq = 1'b1;
    cycle(8'h00);
    chk("irq_rel", a, 16'h7003);
    n_irq = 1'b0;
    cycle(8'h00);
    chk("irq_again", a, 16'hFFFE);
    n_irq = 1'b1;
    cycle(8'h00);
    cycle(8'h71);
    chk("irq_vec2", a, 16'h7100);

    dbg = 1'b1;
    n_irq = 1'b0;
    cycle(8'h00);
    cycle(8'h00);
    chk("irq_dbg", a, 16'h7102);

    dbg = 1'b0;
    n_nmi = 1'b0;
    cycle(8'h00);
    chk("both_nmi_wins", a, 16'hFFFA);
    cycle(8'h00);
    cycle(8'h80);
    chk("both_nmi_vec", a, 16'h8000);
    cycle(8'h00);
    chk("both_irq_next", a, 16'hFFFE);
    n_irq = 1'b1;
    n_nmi = 1'b1;
    cycle(8'h00);
    cycle(8'h81);
    chk("both_irq_vec", a, 16'h8100);

    n_nmi = 1'b0;
    tick();
    n_nmi = 1'b1;
    repeat (7) tick();
    chk("mid_div8", dut.div_q, 8);
    chk("mid_pend_set", dut.nmi_pend_q, 1);
    do_reset();
    chk("mid_div0", dut.div_q, 0);
    chk("mid_m2", m2, 0);
    chk("mid_a", a, 16'hFFFC);
    chk("mid_pend_clr", dut.nmi_pend_q, 0);
    chk("mid_out_clr", {out2, out1, out0}, 3'b000);
    cycle(8'h00);
    cycle(8'h90);
    chk("post_vec", a, 16'h9000);
    cycle(8'h00);
    chk("post_no_nmi", a, 16'h9001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
